// File: rtl/uart_cmd_pkg.sv
// Purpose: shared opcodes, FSM encodings and serial frame helper for the UART command initiator.
// Latency: none (definitions only).
// Backpressure: none. Macro UART_INIT_PARITY_EN adds an even-parity bit to every byte (11 bit times).
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK      = 8'h4B;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SEND_OP   = 3'd1;
    localparam state_t ST_SEND_ADDR = 3'd2;
    localparam state_t ST_SEND_DATA = 3'd3;
    localparam state_t ST_WAIT_RSP  = 3'd4;
    localparam state_t ST_DONE      = 3'd5;

`ifdef UART_INIT_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Serial image of one byte; bit 0 leaves the shifter first (start bit).
    function automatic logic [FRAME_BITS-1:0] tx_frame(input logic [7:0] b);
`ifdef UART_INIT_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/uart_avalon_cmd_initiator_rx.sv
// Purpose: UART byte receiver: 2-FF sync, start-bit validation, bit-centre sampling, stop/parity check.
// Latency: byte_valid/frame_err pulse in the cycle the stop bit centre is sampled.
// Backpressure: none; the consumer must take each pulse or lose it. Parity checked with UART_INIT_PARITY_EN.
module uart_byte_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int HALF   = CLKS_PER_BIT / 2;

    logic              sync1_q, sync2_q, prev_q;
    logic              act_q, act_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              stop_ok;
`ifdef UART_INIT_PARITY_EN
    logic              par_q, par_d;

    assign stop_ok = sync2_q && ((^shift_q) == par_q);
`else
    assign stop_ok = sync2_q;
`endif

    assign byte_data = shift_q;

    // Bit-level receive sequencing: bit 0 is the start bit, 1..8 data, then optional parity, then stop.
    always_comb begin
        act_d      = act_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
`ifdef UART_INIT_PARITY_EN
        par_d      = par_q;
`endif
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (!act_q) begin
            if (prev_q && !sync2_q) begin
                act_d  = 1'b1;
                baud_d = '0;
                bit_d  = 4'd0;
            end
        end else if (bit_q == 4'd0) begin
            // Start bit must still be low half a bit later, otherwise it was a glitch.
            if (baud_q == BAUD_W'(HALF - 1)) begin
                baud_d = '0;
                if (sync2_q) begin
                    act_d = 1'b0;
                end else begin
                    bit_d = 4'd1;
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end else if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
            baud_d = '0;
            if (bit_q <= 4'd8) begin
                shift_d = {sync2_q, shift_q[7:1]};
                bit_d   = bit_q + 4'd1;
`ifdef UART_INIT_PARITY_EN
            end else if (bit_q == 4'd9) begin
                par_d = sync2_q;
                bit_d = bit_q + 4'd1;
`endif
            end else begin
                // Stop bit centre: deliver the byte or flag the broken frame, then wait for the next edge.
                act_d      = 1'b0;
                byte_valid = stop_ok;
                frame_err  = !stop_ok;
            end
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    // Synchronizer, edge history and receive state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            act_q   <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
`ifdef UART_INIT_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            act_q   <= act_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_INIT_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: rtl/uart_avalon_cmd_initiator.sv
// Purpose: serializes one read/write request into a UART command frame and parses the reply.
// Latency: write = (5+ADDR_W/8) bytes out + 1 byte in + 2 cycles; read = (1+ADDR_W/8) out + 4 in + 2.
// Backpressure: req_ready low while a transaction is in flight; requests are not queued. Macro UART_INIT_PARITY_EN.
module uart_avalon_cmd_initiator
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              rs232_tx,
    input  logic              rs232_rx,
    output logic              busy
);

    localparam int NB     = ADDR_W / 8;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         to_q, to_d;
    logic [23:0]         acc_q, acc_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BAUD_W-1:0]     tx_baud_q, tx_baud_d;
    logic [3:0]            tx_bit_q, tx_bit_d;
    logic                  tx_act_q, tx_act_d;
    logic                  tx_bit_end, tx_done, tx_load;
    logic [7:0]            tx_byte;

    logic                  rx_vld, rx_err;
    logic [7:0]            rx_dat;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .rx         (rs232_rx),
        .byte_valid (rx_vld),
        .byte_data  (rx_dat),
        .frame_err  (rx_err)
    );

    assign tx_bit_end = (tx_baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx_done    = tx_act_q && tx_bit_end && (tx_bit_q == 4'(FRAME_BITS - 1));

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;
    assign rs232_tx  = tx_shift_q[0];

    // Transaction sequencing; a new TX byte is loaded in the same cycle the previous stop bit ends.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        to_d    = to_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tx_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_SEND_OP;
                    cnt_d   = 8'd0;
                    tx_load = 1'b1;
                end
            end
            ST_SEND_OP: begin
                if (tx_done) begin
                    state_d = ST_SEND_ADDR;
                    cnt_d   = 8'd0;
                    tx_load = 1'b1;
                end
            end
            ST_SEND_ADDR: begin
                if (tx_done) begin
                    if (cnt_q == 8'(NB - 1)) begin
                        cnt_d = 8'd0;
                        if (write_q) begin
                            state_d = ST_SEND_DATA;
                            tx_load = 1'b1;
                        end else begin
                            state_d = ST_WAIT_RSP;
                            to_d    = 32'd0;
                        end
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        tx_load = 1'b1;
                    end
                end
            end
            ST_SEND_DATA: begin
                if (tx_done) begin
                    if (cnt_q == 8'd3) begin
                        state_d = ST_WAIT_RSP;
                        cnt_d   = 8'd0;
                        to_d    = 32'd0;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        tx_load = 1'b1;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (rx_err) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (rx_vld) begin
                    to_d = 32'd0;
                    if (write_q) begin
                        state_d = ST_DONE;
                        err_d   = (rx_dat != ACK);
                    end else begin
                        acc_d = {acc_q[15:0], rx_dat};
                        if (cnt_q == 8'd3) begin
                            state_d = ST_DONE;
                            err_d   = 1'b0;
                            rdata_d = {acc_q, rx_dat};
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end else if (to_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte to transmit next, chosen from the phase and index being entered (MSB byte first).
    always_comb begin
        tx_byte = 8'h00;
        case (state_d)
            ST_SEND_OP: tx_byte = write_d ? OP_WRITE : OP_READ;
            ST_SEND_ADDR: begin
                for (int i = 0; i < NB; i++) begin
                    if (cnt_d == 8'(i)) tx_byte = addr_d[ADDR_W-1-8*i -: 8];
                end
            end
            ST_SEND_DATA: begin
                for (int i = 0; i < 4; i++) begin
                    if (cnt_d == 8'(i)) tx_byte = wdata_d[31-8*i -: 8];
                end
            end
            default: tx_byte = 8'h00;
        endcase
    end

    // TX shifter: ones fill in from the top so the line rests high once a frame has drained.
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_act_d   = tx_act_q;
        if (tx_load) begin
            tx_shift_d = tx_frame(tx_byte);
            tx_baud_d  = '0;
            tx_bit_d   = 4'd0;
            tx_act_d   = 1'b1;
        end else if (tx_act_q) begin
            if (tx_bit_end) begin
                tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
                tx_baud_d  = '0;
                if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
                    tx_act_d = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_d = tx_baud_q + 1'b1;
            end
        end
    end

    // State registers; reset forces the line high at once, cutting any frame short.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            to_q       <= 32'd0;
            acc_q      <= 24'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= 4'd0;
            tx_act_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            to_q       <= to_d;
            acc_q      <= acc_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_act_q   <= tx_act_d;
        end
    end

endmodule
